// File: rtl/wr_dest_pkg.sv
// Shared constants for the write-destination tracker: selector encodings and
// default register numbers / sizes.
package wr_dest_pkg;

    typedef enum logic [1:0] {
        SRC_RT = 2'd0,
        SRC_SP = 2'd1,
        SRC_RA = 2'd2,
        SRC_RD = 2'd3
    } src_sel_e;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_SP_REG = 29;
    localparam int DEF_RA_REG = 31;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wr_dest_tracker_if.sv
// Issue/writeback/hazard bundle of the write-destination tracker.
interface wr_dest_tracker_if
    import wr_dest_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [1:0]        selector;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              push;
    logic              push_ready;
    logic              wb_done;
    logic [ADDR_W-1:0] dest_addr;
    logic              dest_valid;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic              hazard_rs;
    logic              hazard_rt;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  selector, rt_addr, rd_addr, push, wb_done, rs_q, rt_q,
        output push_ready, dest_addr, dest_valid, hazard_rs, hazard_rt, count
    );

    modport master (
        output selector, rt_addr, rd_addr, push, wb_done, rs_q, rt_q,
        input  push_ready, dest_addr, dest_valid, hazard_rs, hazard_rt, count
    );

endinterface

// File: rtl/wr_dest_fifo.sv
// Circular buffer of pending destinations with per-entry valid bits; all
// entries are exposed so the parent can compare against every one of them.
module wr_dest_fifo #(
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [ADDR_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_mem,
    output logic [DEPTH-1:0]             o_valid,
    output logic [PTR_W-1:0]             o_head,
    output logic [CNT_W-1:0]             o_count
);

    logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
    logic [DEPTH-1:0]             r_valid;
    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;

    // When full, head==tail on a push+pop; the push's valid set is written
    // last so the refilled slot stays valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem   <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (i_push) begin
                r_mem[r_tail]   <= i_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_mem   = r_mem;
    assign o_valid = r_valid;
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/wr_dest_tracker.sv
// Tracks destinations of in-flight register writes and flags RAW hazards.
// Optional WR_DEST_BYPASS_EN: head entry ignored for hazards while it retires.
module wr_dest_tracker
    import wr_dest_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SP_REG = DEF_SP_REG,
    parameter int RA_REG = DEF_RA_REG
) (
    input  logic               clk,
    input  logic               reset,
    wr_dest_tracker_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0]            w_dest_sel;
    logic                         w_push_ready;
    logic                         w_push_acc;
    logic                         w_pop;
    logic [DEPTH-1:0][ADDR_W-1:0] w_mem;
    logic [DEPTH-1:0]             w_valid;
    logic [PTR_W-1:0]             w_head;
    logic [CNT_W-1:0]             w_count;
    logic                         w_head_valid;
    logic [DEPTH-1:0]             w_cmp_en;
    logic [DEPTH-1:0]             w_hit_rs;
    logic [DEPTH-1:0]             w_hit_rt;

    always_comb begin
        w_dest_sel = bus.rt_addr;
        case (src_sel_e'(bus.selector))
            SRC_RT:  w_dest_sel = bus.rt_addr;
            SRC_SP:  w_dest_sel = ADDR_W'(SP_REG);
            SRC_RA:  w_dest_sel = ADDR_W'(RA_REG);
            SRC_RD:  w_dest_sel = bus.rd_addr;
            default: w_dest_sel = bus.rt_addr;
        endcase
    end

    assign w_head_valid = w_valid[w_head];
    assign w_push_ready = (w_count < CNT_W'(DEPTH)) | bus.wb_done;
    assign w_push_acc   = bus.push & w_push_ready;
    assign w_pop        = bus.wb_done & w_head_valid;

    wr_dest_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_acc),
        .i_data  (w_dest_sel),
        .i_pop   (w_pop),
        .o_mem   (w_mem),
        .o_valid (w_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_cmp_en = w_valid;
`ifdef WR_DEST_BYPASS_EN
        if (bus.wb_done) w_cmp_en[w_head] = 1'b0;
`endif
    end

    // Only registered entries take part; a same-cycle push is not yet stored.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign w_hit_rs[i] = w_cmp_en[i] && (w_mem[i] == bus.rs_q);
        assign w_hit_rt[i] = w_cmp_en[i] && (w_mem[i] == bus.rt_q);
    end

    assign bus.hazard_rs  = (|w_hit_rs) && (bus.rs_q != '0);
    assign bus.hazard_rt  = (|w_hit_rt) && (bus.rt_q != '0);
    assign bus.push_ready = w_push_ready;
    assign bus.dest_valid = w_head_valid;
    assign bus.dest_addr  = w_head_valid ? w_mem[w_head] : '0;
    assign bus.count      = w_count;

endmodule

// File: tb/tb_wr_dest_tracker.sv
// Bench for wr_dest_tracker with a queue-based reference model.
module tb_wr_dest_tracker;

    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    logic [AW-1:0] q[$];
    logic [AW-1:0] exp_seq[4];

    wr_dest_tracker_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus();

    wr_dest_tracker #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .SP_REG (29),
        .RA_REG (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] decode(input logic [1:0] sel, input logic [AW-1:0] rt,
                                             input logic [AW-1:0] rd);
        case (sel)
            2'd0:    return rt;
            2'd1:    return 5'd29;
            2'd2:    return 5'd31;
            default: return rd;
        endcase
    endfunction

    function automatic logic exp_haz(input logic [AW-1:0] r, input logic wb);
        if (r == 0) return 1'b0;
        for (int i = 0; i < q.size(); i++) begin
`ifdef WR_DEST_BYPASS_EN
            if (i == 0 && wb) continue;
`endif
            if (q[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic p, input logic [1:0] sel, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic wb,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rtq);
        logic rdy;
        bus.push = p; bus.selector = sel; bus.rt_addr = rt; bus.rd_addr = rd;
        bus.wb_done = wb; bus.rs_q = rs; bus.rt_q = rtq;
        @(negedge clk);
        rdy = (q.size() < DEPTH) || wb;
        chk("push_ready", 32'(bus.push_ready), 32'(rdy));
        chk("dest_valid", 32'(bus.dest_valid), 32'(q.size() != 0));
        chk("dest_addr",  32'(bus.dest_addr),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("count",      32'(bus.count),      32'(q.size()));
        chk("hazard_rs",  32'(bus.hazard_rs),  32'(exp_haz(rs, wb)));
        chk("hazard_rt",  32'(bus.hazard_rt),  32'(exp_haz(rtq, wb)));
        @(posedge clk);
        if (wb && q.size() > 0) void'(q.pop_front());
        if (p && rdy) q.push_back(decode(sel, rt, rd));
        #1;
    endtask

    task automatic idle_pop();
        step(1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b0;
        bus.push = 0; bus.selector = 0; bus.rt_addr = 0; bus.rd_addr = 0;
        bus.wb_done = 0; bus.rs_q = 0; bus.rt_q = 0;
        #12;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.dest_valid), 32'd0);
        chk("rst_addr",  32'(bus.dest_addr), 32'd0);
        chk("rst_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_haz",   32'({bus.hazard_rs, bus.hazard_rt}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // First push of SP appears one cycle later
        step(1'b1, 2'd1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        chk("sp_addr",  32'(bus.dest_addr), 32'd29);
        chk("sp_valid", 32'(bus.dest_valid), 32'd1);
        chk("sp_count", 32'(bus.count), 32'd1);
        idle_pop();

        // Fill, overflow attempt, drain in order
        step(1'b1, 2'd0, 5'd8, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd3, 5'd0, 5'd9, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd2, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_ready", 32'(bus.push_ready), 32'd0);
        step(1'b1, 2'd0, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0);
        chk("drop_count", 32'(bus.count), 32'd4);
        exp_seq = '{5'd8, 5'd9, 5'd31, 5'd29};
        for (int i = 0; i < 4; i++) begin
            chk("drain_a", 32'(bus.dest_addr), 32'(exp_seq[i]));
            idle_pop();
        end

        // Full queue with simultaneous push and retire
        step(1'b1, 2'd0, 5'd8, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd3, 5'd0, 5'd9, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd2, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd3, 5'd0, 5'd12, 1'b1, 5'd0, 5'd0);
        chk("swap_count", 32'(bus.count), 32'd4);
        exp_seq = '{5'd9, 5'd31, 5'd29, 5'd12};
        for (int i = 0; i < 4; i++) begin
            chk("drain_b", 32'(bus.dest_addr), 32'(exp_seq[i]));
            idle_pop();
        end

        // Hazards against {8,0}, register 0 never flagged
        step(1'b1, 2'd0, 5'd8, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        bus.push = 0; bus.wb_done = 0; bus.rs_q = 5'd8; bus.rt_q = 5'd0;
        #1;
        chk("haz_rs8", 32'(bus.hazard_rs), 32'd1);
        chk("haz_rt0", 32'(bus.hazard_rt), 32'd0);
        bus.wb_done = 1;
        #1;
`ifdef WR_DEST_BYPASS_EN
        chk("haz_rs8_wb", 32'(bus.hazard_rs), 32'd0);
`else
        chk("haz_rs8_wb", 32'(bus.hazard_rs), 32'd1);
`endif
        step(1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd8, 5'd0);
        idle_pop();

        // Reset in the middle of operation
        step(1'b1, 2'd0, 5'd3, 5'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd3, 5'd0, 5'd4, 1'b0, 5'd0, 5'd0);
        step(1'b1, 2'd1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0);
        bus.push = 0; bus.wb_done = 0; bus.rs_q = 5'd3; bus.rt_q = 5'd29;
        reset = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus.dest_valid), 32'd0);
        chk("mrst_count", 32'(bus.count), 32'd0);
        chk("mrst_haz",   32'({bus.hazard_rs, bus.hazard_rt}), 32'd0);
        chk("mrst_ready", 32'(bus.push_ready), 32'd1);
        q.delete();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 2'd2, 5'd0, 5'd0, 1'b0, 5'd3, 5'd29);
        chk("post_rst_ra", 32'(bus.dest_addr), 32'd31);
        idle_pop();

        // Retire on empty queue is ignored
        idle_pop();
        chk("empty_wb_count", 32'(bus.count), 32'd0);
        chk("empty_wb_valid", 32'(bus.dest_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 40,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_dest_tracker.md
WR_DEST_TRACKER -- requirements
Module: wr_dest_tracker

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning pending-destination queue entries (power of 2, >=2).
REQ-003 SHALL have parameter SP_REG, default 29, meaning fixed destination for source 1.
REQ-004 SHALL have parameter RA_REG, default 31, meaning fixed destination for source 2.
REQ-005 SHALL have port clk  in  1  the single clock, all state rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port selector  in  2  destination source: 0=rt, 1=SP_REG, 2=RA_REG, 3=rd.
REQ-008 SHALL have port rt_addr  in  ADDR_W  instruction [20:16] field.
REQ-009 SHALL have port rd_addr  in  ADDR_W  instruction [15:11] field.
REQ-010 SHALL have port push  in  1  issue of a register-writing instruction.
REQ-011 SHALL have port push_ready  out  1  queue can accept a push this cycle.
REQ-012 SHALL have port wb_done  in  1  oldest pending write retires this cycle.
REQ-013 SHALL have port dest_addr  out  ADDR_W  registered destination of oldest pending write.
REQ-014 SHALL have port dest_valid  out  1  dest_addr holds a pending entry.
REQ-015 SHALL have port rs_q, rt_q  in  ADDR_W each  source registers of the next instruction.
REQ-016 SHALL have port hazard_rs, hazard_rt  out  1 each  source matches a pending destination.
REQ-017 SHALL have port count  out  $clog2(DEPTH)+1  pending entries.

Function
REQ-018 SHALL decode selector combinationally to a destination and enqueue it at the tail on the clock edge when push && push_ready.
REQ-019 SHALL set push_ready = (count < DEPTH) || wb_done.
REQ-020 SHALL dequeue the head on the edge when wb_done && dest_valid; wb_done with empty queue SHALL be ignored, count unchanged.
REQ-021 SHALL, on simultaneous accepted push and dequeue, leave count unchanged, including when full.
REQ-022 SHALL discard a push while push_ready=0 with no state change.
REQ-023 SHALL present a push to an empty queue on dest_addr/dest_valid one cycle after the accepting edge (latency 1).
REQ-024 SHALL wrap head/tail pointers modulo DEPTH.
REQ-025 SHALL assert hazard_rs (hazard_rt) combinationally when rs_q (rt_q) is nonzero and equals any valid entry.
REQ-026 SHALL never flag a hazard for register 0; destination 0 SHALL still be queued.
REQ-027 SHALL not include a push in the same cycle in the hazard compare.

Reset
REQ-028 SHALL, on reset low, asynchronously clear pointers, count=0, dest_valid=0, dest_addr=0, all entry valid bits 0.
REQ-029 SHALL drive hazard_rs=hazard_rt=0 and push_ready=1 while reset is low.
REQ-030 SHALL drop all pending entries on reset mid-operation; no entry survives.

Configuration
REQ-031 SHALL, with WR_DEST_BYPASS_EN defined, exclude the head entry from hazard compare in a cycle where wb_done=1 (writeback forwards that value).
REQ-032 SHALL, without WR_DEST_BYPASS_EN, include the head entry regardless of wb_done.

Structure
REQ-033 SHALL take selector encodings (SRC_RT, SRC_SP, SRC_RA, SRC_RD) and default register constants from shared package wr_dest_pkg.
REQ-034 SHALL implement storage as sub-module wr_dest_fifo (circular buffer with per-entry valid bits, exposing all entries for compare).

Verification
REQ-035 Reset, then push sel=1 -> next cycle dest_addr=29, dest_valid=1, count=1.
REQ-036 Push sel=0 rt=8, sel=3 rd=9, sel=2, sel=1 -> count=4, push_ready=0; fifth push sel=0 rt=5 dropped; dequeues yield 8,9,31,29.
REQ-037 Full queue, push sel=3 rd=12 with wb_done=1 -> accepted, count stays 4, tail wraps, head advances.
REQ-038 Pending {8,0}, rs_q=8 rt_q=0 -> hazard_rs=1, hazard_rt=0; with wb_done=1 and head=8: hazard_rs=0 only if WR_DEST_BYPASS_EN.
REQ-039 Three entries queued, reset low mid-cycle -> immediately dest_valid=0, count=0, hazards 0; after release a push sel=2 -> dest_addr=31.
REQ-040 wb_done=1 on empty queue -> count stays 0, dest_valid stays 0.
